// File: rtl/tama_input_conditioner.sv
// Conditions the raw push buttons and the tilt sensor. Each input is synchronized
// and then debounced. Button presses become single-cycle events. A long hold on
// the test button enters a test mode. In test mode, play presses step a 1..9
// scenario code and the normal press events are suppressed.
module tama_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES  = 500000,
   parameter int unsigned LONGPRESS_CYCLES = 250000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_sleep_n,
   input  logic       btn_awake_n,
   input  logic       btn_feed_n,
   input  logic       btn_play_n,
   input  logic       btn_test_n,
   input  logic       tilt_raw,
   output logic       sleep_pulse,
   output logic       awake_pulse,
   output logic       feed_pulse,
   output logic       play_pulse,
   output logic       tilt,
   output logic       test_mode,
   output logic [3:0] test_code
);

   localparam int NCH      = 6;
   localparam int CH_SLEEP = 0;
   localparam int CH_AWAKE = 1;
   localparam int CH_FEED  = 2;
   localparam int CH_PLAY  = 3;
   localparam int CH_TEST  = 4;
   localparam int CH_TILT  = 5;

   localparam int DB_W   = (DEBOUNCE_CYCLES  > 1) ? $clog2(DEBOUNCE_CYCLES)  : 1;
   localparam int HOLD_W = (LONGPRESS_CYCLES > 1) ? $clog2(LONGPRESS_CYCLES) : 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_CYCLES - 1);

   typedef enum logic [1:0] {
      T_OFF    = 2'd0,
      T_ARM    = 2'd1,
      T_ACTIVE = 2'd2,
      T_EXIT   = 2'd3
   } t_state_e;

   // All channels are normalised to active-high "pressed" before synchronizing.
   // As a result, the reset value 0 means released everywhere.
   logic [NCH-1:0] raw_act;
   assign raw_act = {tilt_raw, ~btn_test_n, ~btn_play_n, ~btn_feed_n, ~btn_awake_n, ~btn_sleep_n};

   logic [NCH-1:0]     sync1_q, sync1_d;
   logic [NCH-1:0]     sync2_q, sync2_d;
   logic [DB_W-1:0]    db_cnt_q [NCH];
   logic [DB_W-1:0]    db_cnt_d [NCH];
   logic [NCH-1:0]     deb_q, deb_d;
   logic [CH_TEST:0]   deb_prev_q, deb_prev_d;
   logic [CH_TEST:0]   ev_q, ev_d;
   t_state_e           state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [3:0]         code_q, code_d;
   logic               mask_pulses;

   // Two-flop synchronizer chain per input.
   always_comb begin
      sync1_d = raw_act;
      sync2_d = sync1_q;
   end

   // Debounce: count consecutive disagreeing samples and accept the change on the last one.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NCH; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Press events: one cycle after the debounced level rises.
   always_comb begin
      deb_prev_d = deb_q[CH_TEST:0];
      ev_d       = deb_q[CH_TEST:0] & ~deb_prev_q;
   end

   // Test-mode control: arm on press, activate after the long hold, exit on a fresh press.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      code_d  = code_q;
      case (state_q)
         T_OFF: begin
            if (deb_q[CH_TEST]) begin
               state_d = T_ARM;
               hold_d  = '0;
            end
         end
         T_ARM: begin
            if (!deb_q[CH_TEST]) begin
               state_d = T_OFF;
            end else if (hold_q == HOLD_LAST) begin
               state_d = T_ACTIVE;
               code_d  = 4'd0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         T_ACTIVE: begin
            // An exit press wins over a coincident play press.
            if (ev_q[CH_TEST]) begin
               state_d = T_EXIT;
            end else if (ev_q[CH_PLAY]) begin
               code_d = (code_q == 4'd9) ? 4'd1 : code_q + 4'd1;
            end
         end
         T_EXIT: begin
            if (!deb_q[CH_TEST]) begin
               state_d = T_OFF;
            end
         end
         default: state_d = T_OFF;
      endcase
   end

   // State registers; the reset forces every input to the released state and the FSM to T_OFF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         for (int i = 0; i < NCH; i++) begin
            db_cnt_q[i] <= '0;
         end
         deb_q      <= '0;
         deb_prev_q <= '0;
         ev_q       <= '0;
         state_q    <= T_OFF;
         hold_q     <= '0;
         code_q     <= 4'd0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         for (int i = 0; i < NCH; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         ev_q       <= ev_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
         code_q     <= code_d;
      end
   end

   assign mask_pulses = (state_q == T_ACTIVE) || (state_q == T_EXIT);
   assign sleep_pulse = ev_q[CH_SLEEP] & ~mask_pulses;
   assign awake_pulse = ev_q[CH_AWAKE] & ~mask_pulses;
   assign feed_pulse  = ev_q[CH_FEED]  & ~mask_pulses;
   assign play_pulse  = ev_q[CH_PLAY]  & ~mask_pulses;
   assign tilt        = deb_q[CH_TILT];
   assign test_mode   = (state_q == T_ACTIVE);
   assign test_code   = code_q;

endmodule

// File: tb/tb_tama_input_conditioner.sv
// Testbench for tama_input_conditioner using short debounce/long-press parameters.
// A reference model predicts every output cycle into a queue, and a monitor pops and compares.
module tb_tama_input_conditioner;

   localparam int D = 4;
   localparam int L = 20;
   localparam int M_OFF = 0, M_ARM = 1, M_ACTIVE = 2, M_EXIT = 3;

   logic       clk;
   logic       rst = 1'b1;
   logic [5:0] press = '0;   // 0 sleep, 1 awake, 2 feed, 3 play, 4 test, 5 tilt (1 = active)
   logic       sleep_pulse, awake_pulse, feed_pulse, play_pulse, tilt, test_mode;
   logic [3:0] test_code;

   int nchecks = 0;
   int nerr    = 0;
   int cyc     = 0;
   int pcount [4] = '{default: 0};
   int plast  [4] = '{default: 0};

   logic [5:0] sq [$];
   logic [9:0] expq [$];
   logic [5:0] m_deb, m_deb_prev;
   logic [4:0] m_ev;
   int         m_mode, m_code, arm_edge;

   tama_input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .LONGPRESS_CYCLES(L)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_sleep_n(~press[0]),
      .btn_awake_n(~press[1]),
      .btn_feed_n (~press[2]),
      .btn_play_n (~press[3]),
      .btn_test_n (~press[4]),
      .tilt_raw   (press[5]),
      .sleep_pulse(sleep_pulse),
      .awake_pulse(awake_pulse),
      .feed_pulse (feed_pulse),
      .play_pulse (play_pulse),
      .tilt       (tilt),
      .test_mode  (test_mode),
      .test_code  (test_code)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // True when the last D synchronized samples all disagree with the current debounced value.
   function automatic bit stable_other(input int ch, input logic cur);
      for (int i = 2; i <= D + 1; i++) begin
         if (sq[sq.size() - 1 - i][ch] == cur) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Reference model: predicts the outputs that follow each rising edge.
   initial begin : ref_model
      logic [5:0] nd;
      logic [4:0] nev;
      int         nmode;
      logic [3:0] pl;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            sq.delete();
            for (int i = 0; i < D + 2; i++) sq.push_back(6'd0);
            m_deb = '0; m_deb_prev = '0; m_ev = '0;
            m_mode = M_OFF; m_code = 0; arm_edge = 0;
            expq.push_back(10'd0);
         end else begin
            sq.push_back(press);
            void'(sq.pop_front());
            nd = m_deb;
            for (int ch = 0; ch < 6; ch++) begin
               if (stable_other(ch, m_deb[ch])) nd[ch] = ~m_deb[ch];
            end
            nev = m_deb[4:0] & ~m_deb_prev[4:0];
            nmode = m_mode;
            case (m_mode)
               M_OFF:    if (m_deb[4]) begin nmode = M_ARM; arm_edge = cyc; end
               M_ARM:    if (!m_deb[4]) nmode = M_OFF;
                         else if (cyc - arm_edge == L) begin nmode = M_ACTIVE; m_code = 0; end
               M_ACTIVE: if (m_ev[4]) nmode = M_EXIT;
                         else if (m_ev[3]) m_code = (m_code == 9) ? 1 : m_code + 1;
               default:  if (!m_deb[4]) nmode = M_OFF;
            endcase
            m_deb_prev = m_deb;
            m_deb      = nd;
            m_ev       = nev;
            m_mode     = nmode;
            pl = (nmode == M_ACTIVE || nmode == M_EXIT) ? 4'b0000 : nev[3:0];
            expq.push_back({pl, nd[5], (nmode == M_ACTIVE), 4'(m_code)});
         end
      end
   end

   // Monitor: one expected vector per cycle; reset forces the all-zero expectation.
   initial begin : monitor
      logic [9:0] e, got;
      forever begin
         @(negedge clk);
         got = {play_pulse, feed_pulse, awake_pulse, sleep_pulse, tilt, test_mode, test_code};
         if (expq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            e = expq.pop_front();
            if (rst) e = '0;
            chk("outputs", {22'd0, got}, {22'd0, e});
         end
         for (int i = 0; i < 4; i++) begin
            if (got[6 + i] === 1'b1) begin
               pcount[i]++;
               plast[i] = cyc;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_for(input int ch, input int n, input int gap);
      press[ch] = 1'b1;
      tick(n);
      press[ch] = 1'b0;
      tick(gap);
   endtask

   task automatic enter_test();
      press[4] = 1'b1;
      tick(30);
      press[4] = 1'b0;
      tick(12);
   endtask

   initial begin : stimulus
      int k, p0;
      int hold_left [6];
      // Reset with every input active: outputs must stay quiet.
      press = 6'h3f;
      tick(4);
      chk("reset_outputs", {22'd0, play_pulse, feed_pulse, awake_pulse, sleep_pulse, tilt, test_mode, test_code}, 32'd0);
      press = '0;
      rst   = 1'b0;
      tick(10);

      // Steady feed press: one pulse, 7 cycles after the change; nothing more while held or on release.
      k = cyc; p0 = pcount[2];
      press[2] = 1'b1;
      tick(100);
      chk("feed_latency", plast[2] - k, 7);
      chk("feed_single", pcount[2] - p0, 1);
      press[2] = 1'b0;
      tick(12);
      chk("feed_release", pcount[2] - p0, 1);

      // Play glitch rejected, real press accepted.
      p0 = pcount[3];
      press_for(3, 3, 12);
      chk("play_glitch", pcount[3] - p0, 0);
      press_for(3, 10, 12);
      chk("play_press", pcount[3] - p0, 1);

      // Long hold enters test mode; play presses step the code silently; test press exits.
      press[4] = 1'b1;
      tick(30);
      chk("tm_enter", test_mode, 1);
      chk("tm_code0", test_code, 0);
      press[4] = 1'b0;
      tick(12);
      p0 = pcount[3];
      for (int i = 0; i < 4; i++) press_for(3, 10, 10);
      chk("tm_code4", test_code, 4);
      chk("tm_play_masked", pcount[3] - p0, 0);
      press[4] = 1'b1;
      tick(10);
      chk("tm_exit", test_mode, 0);
      chk("tm_code_hold", test_code, 4);
      press[4] = 1'b0;
      tick(12);

      // Code wrap: 1..9 then 1.
      enter_test();
      for (int n = 1; n <= 10; n++) begin
         press_for(3, 10, 10);
         chk("code_seq", test_code, (n <= 9) ? n : 1);
      end
      press_for(4, 10, 12);

      // Short test hold does not arm test mode; normal pulses continue.
      press_for(4, 10, 12);
      chk("short_hold", test_mode, 0);
      p0 = pcount[0];
      press_for(0, 10, 10);
      chk("sleep_after", pcount[0] - p0, 1);

      // Reset in test mode with code 5; a held feed button pulses after full latency.
      enter_test();
      for (int i = 0; i < 5; i++) press_for(3, 10, 10);
      chk("code5", test_code, 5);
      press[2] = 1'b1;
      tick(10);
      rst = 1'b1;
      #1;
      chk("rst_mode", test_mode, 0);
      chk("rst_code", test_code, 0);
      chk("rst_pulses", {28'd0, play_pulse, feed_pulse, awake_pulse, sleep_pulse}, 0);
      tick(3);
      rst = 1'b0;
      k = cyc; p0 = pcount[2];
      tick(20);
      chk("rst_held_latency", plast[2] - k, 7);
      chk("rst_held_count", pcount[2] - p0, 1);
      press[2] = 1'b0;
      tick(12);

      // Randomized mix of glitches, presses, long holds and occasional resets.
      for (int ch = 0; ch < 6; ch++) hold_left[ch] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int ch = 0; ch < 6; ch++) begin
            if (hold_left[ch] == 0) begin
               int r;
               r = int'($urandom_range(0, 9));
               press[ch] = 1'($urandom_range(0, 1));
               if (r < 3)      hold_left[ch] = int'($urandom_range(1, 3));
               else if (r < 7) hold_left[ch] = int'($urandom_range(4, 12));
               else            hold_left[ch] = int'($urandom_range(13, 45));
            end
            hold_left[ch]--;
         end
         if ($urandom_range(0, 1499) == 0) begin
            rst = 1'b1;
            tick(2);
            rst = 1'b0;
         end
         tick(1);
      end

      press = '0;
      tick(60);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule

// File: doc/tama_input_conditioner.md
TAMA_INPUT_CONDITIONER -- requirements
Module: tama_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable-sample count (10 ms at 50 MHz) needed to accept an input change.
REQ-002 SHALL have parameter LONGPRESS_CYCLES, default 250000000, giving the debounced test-button hold time (5 s) needed to enter test mode.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports btn_sleep_n, btn_awake_n, btn_feed_n, btn_play_n, btn_test_n, input, 1 bit each: raw push buttons, active-low, asynchronous to clk.
REQ-006 SHALL have port tilt_raw, input, 1 bit: raw tilt sensor, active-high, asynchronous.
REQ-007 SHALL have ports sleep_pulse, awake_pulse, feed_pulse, play_pulse, output, 1 bit each: single-cycle press events.
REQ-008 SHALL have port tilt, output, 1 bit: debounced tilt level.
REQ-009 SHALL have port test_mode, output, 1 bit: test-mode level.
REQ-010 SHALL have port test_code, output, 4 bits: selected test scenario, range 0..9.

Function
REQ-011 Every raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each input SHALL have its own debouncer: counter increments while synchronized value differs from debounced value, clears on any agreement, debounced value toggles and counter clears when counter reaches DEBOUNCE_CYCLES-1.
REQ-013 Latency SHALL be exactly DEBOUNCE_CYCLES+2 cycles from a steady raw change to debounced change; glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-014 Press events SHALL be registered: *_pulse high for exactly one cycle, the cycle after the debounced pressed level rises; release produces no pulse.
REQ-015 Holding a button SHALL produce one pulse only; simultaneous presses of different buttons SHALL each produce their own pulse in the same cycle.
REQ-016 tilt SHALL equal the debounced tilt_raw level, no edge detection.
REQ-017 Test control FSM states: T_OFF, T_ARM, T_ACTIVE, T_EXIT.
REQ-018 T_OFF -> T_ARM when debounced test button pressed; hold counter cleared.
REQ-019 T_ARM: hold counter increments each cycle while pressed; release before LONGPRESS_CYCLES-1 -> T_OFF with no output change; reaching LONGPRESS_CYCLES-1 -> T_ACTIVE, test_mode=1, test_code=0.
REQ-020 T_ACTIVE: each play press (play_pulse condition) SHALL increment test_code, 9 wraps to 1; test-button press event (after release of entering hold) -> T_EXIT.
REQ-021 In T_ACTIVE and T_EXIT, sleep_pulse, awake_pulse, feed_pulse, play_pulse SHALL be forced 0; tilt unaffected.
REQ-022 Entering T_EXIT SHALL clear test_mode same edge; T_EXIT -> T_OFF on debounced test release.
REQ-023 test_code SHALL hold its value after exit until the next T_ARM -> T_ACTIVE transition clears it.
REQ-024 A test-button press in T_ACTIVE coinciding with a play press SHALL take exit; test_code not incremented.
REQ-025 The hold counter SHALL be wide enough for LONGPRESS_CYCLES (clog2 width) and SHALL not wrap.

Reset
REQ-026 rst SHALL asynchronously clear synchronizers, debouncers (debounced level = not pressed, tilt = 0), all counters, FSM to T_OFF.
REQ-027 During and after reset: all *_pulse = 0, tilt = 0, test_mode = 0, test_code = 0.
REQ-028 Reset asserted mid-hold or in T_ACTIVE SHALL abort to T_OFF; a button still held at release of rst SHALL produce a pulse after full debounce latency.

Verification (DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=20)
REQ-029 btn_feed_n low steady -> feed_pulse high exactly one cycle, 7 cycles after first low sample; held 100 cycles -> no further pulse.
REQ-030 btn_play_n 3-cycle low glitch -> no play_pulse; 10-cycle low -> one play_pulse.
REQ-031 btn_test_n held 30 cycles -> test_mode=1, test_code=0; then 4 play presses -> test_code=4, play_pulse stays 0; test press -> test_mode=0, test_code stays 4.
REQ-032 In test mode, 10 play presses -> test_code sequence 1..9 then 1.
REQ-033 btn_test_n held 10 cycles then released -> test_mode stays 0, sleep press afterward -> sleep_pulse normal.
REQ-034 rst pulsed in T_ACTIVE with test_code=5 -> test_mode=0, test_code=0, all pulses 0 immediately.
